// File: rtl/ps2_host_tx_if.sv
// Host-side command bus and PS/2 line hooks for the host-to-device transmitter.
// The transmitter only drives open-drain pull-down enables; the tristate lives elsewhere.
interface ps2_host_tx_if;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output tx_data, tx_start, ps2_clk_in, ps2_data_in,
        input  ps2_clk_oe, ps2_data_oe, busy, done, err
    );

    modport slave (
        input  tx_data, tx_start, ps2_clk_in, ps2_data_in,
        output ps2_clk_oe, ps2_data_oe, busy, done, err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, then shifts
// one command byte (odd parity, stop) out on device clock falls and checks the ACK.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 12000,
    parameter int unsigned TIMEOUT_CYCLES = 1500000
) (
    input  logic         clk,
    input  logic         rst,
    ps2_host_tx_if.slave bus
);

    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                        : TIMEOUT_CYCLES;
    localparam int unsigned CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_REQ,
        S_ACK,
        S_WAIT_IDLE,
        S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic          data_oe_q, data_oe_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic clk_s1_q, clk_s2_q, clk_prev_q;
    logic data_s1_q, data_s2_q;
    logic fall;
    logic timeout;

    // Synchronizers idle high so a reset never fabricates a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            data_s1_q  <= 1'b1;
            data_s2_q  <= 1'b1;
        end else begin
            clk_s1_q   <= bus.ps2_clk_in;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            data_s1_q  <= bus.ps2_data_in;
            data_s2_q  <= data_s1_q;
        end
    end

    assign fall    = clk_prev_q & ~clk_s2_q;
    assign timeout = ~fall & (cnt_q == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shift_q   <= '1;
            bitcnt_q  <= '0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            bitcnt_q  <= bitcnt_d;
            data_oe_q <= data_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        bitcnt_d  = bitcnt_q;
        data_oe_d = data_oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                data_oe_d = 1'b0;
                if (bus.tx_start) begin
                    state_d  = S_INHIBIT;
                    cnt_d    = '0;
                    shift_d  = {1'b1, ~^bus.tx_data, bus.tx_data};
                    bitcnt_d = '0;
                    busy_d   = 1'b1;
                end
            end

            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    state_d   = S_START;
                    data_oe_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_START: begin
                state_d = S_REQ;
                cnt_d   = '0;
            end

            S_REQ, S_ACK, S_WAIT_IDLE: begin
                cnt_d = fall ? '0 : cnt_q + 1'b1;
                // A missing device edge wins over any progress made in the same cycle.
                if (timeout) begin
                    state_d   = S_ERR;
                    data_oe_d = 1'b0;
                    busy_d    = 1'b0;
                    err_d     = 1'b1;
                end else if (state_q == S_REQ) begin
                    if (fall) begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = {1'b0, shift_q[9:1]};
                        bitcnt_d  = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd9) begin
                            state_d = S_ACK;
                        end
                    end
                end else if (state_q == S_ACK) begin
                    if (fall) begin
                        data_oe_d = 1'b0;
                        if (data_s2_q) begin
                            state_d = S_ERR;
                            busy_d  = 1'b0;
                            err_d   = 1'b1;
                        end else begin
                            state_d = S_WAIT_IDLE;
                        end
                    end
                end else begin
                    if (clk_s2_q && data_s2_q) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end

            S_ERR: begin
                state_d   = S_IDLE;
                data_oe_d = 1'b0;
                busy_d    = 1'b0;
            end

            default: begin
                state_d   = S_IDLE;
                data_oe_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    assign bus.ps2_clk_oe  = (state_q == S_INHIBIT) || (state_q == S_START);
    assign bus.ps2_data_oe = data_oe_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a behavioural PS/2 device model plus a
// scoreboard that matches every done/err pulse against the queued expectation.
module tb_ps2_host_tx;

    localparam int INH = 100;
    localparam int TO  = 5000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;

    ps2_host_tx_if bus_if ();

    assign bus_if.ps2_clk_in  = ~(bus_if.ps2_clk_oe  | dev_clk_low);
    assign bus_if.ps2_data_in = ~(bus_if.ps2_data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        bit         chk_bits;
        logic [9:0] bits;
    } exp_t;

    exp_t       exp_q[$];
    logic [9:0] obs_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame as seen on the wire after falls 1..10: d0..d7, odd parity, stop.
    function automatic logic [9:0] ref_frame(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
    endfunction

    task automatic expect_result(input bit is_err, input bit chk, input logic [9:0] bits);
        exp_t e;
        e.is_err   = is_err;
        e.chk_bits = chk;
        e.bits     = bits;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        bus_if.tx_data  = d;
        bus_if.tx_start = 1'b1;
        @(negedge clk);
        bus_if.tx_start = 1'b0;
    endtask

    task automatic wait_not_busy();
        int w = 0;
        while (bus_if.busy && w < 20000) begin
            @(negedge clk);
            w++;
        end
        check("busy_clear_wait", 32'(w < 20000), 32'd1);
    endtask

    // Device side: waits for the request-to-send, then clocks nfalls falls and
    // samples host data just before each rising edge; optionally drives the ACK.
    task automatic device(input bit ack, input int nfalls, input int half);
        int         w   = 0;
        logic [9:0] got = '0;
        while (!(bus_if.ps2_clk_oe == 1'b0 && bus_if.ps2_data_oe == 1'b1) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check("request_seen", 32'(w < 2000), 32'd1);
        if (w >= 2000) return;
        repeat (half) @(negedge clk);
        for (int k = 1; k <= nfalls; k++) begin
            if (k == 11 && ack) dev_data_low = 1'b1;
            dev_clk_low = 1'b1;
            repeat (half) @(negedge clk);
            if (k <= 10) got[k-1] = bus_if.ps2_data_in;
            if (k == 10) obs_q.push_back(got);
            dev_clk_low = 1'b0;
            repeat (half) @(negedge clk);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] d, input bit ack, input int half);
        expect_result(!ack, 1'b1, ref_frame(d));
        fork
            begin send(d); wait_not_busy(); end
            device(ack, 11, half);
        join
        repeat (5) @(negedge clk);
    endtask

    // Scoreboard monitor
    initial begin
        exp_t       e;
        logic [9:0] o;
        forever begin
            @(negedge clk);
            if (!rst && (bus_if.done || bus_if.err)) begin
                check("done_err_exclusive", 32'(bus_if.done & bus_if.err), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {bus_if.done, bus_if.err}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result_is_err", 32'(bus_if.err), 32'(e.is_err));
                    check("pulse_clk_released", 32'(bus_if.ps2_clk_oe), 32'd0);
                    check("pulse_data_released", 32'(bus_if.ps2_data_oe), 32'd0);
                    check("pulse_busy_low", 32'(bus_if.busy), 32'd0);
                    if (e.chk_bits) begin
                        if (obs_q.size() == 0) begin
                            check("frame_captured", 32'd0, 32'd1);
                        end else begin
                            o = obs_q.pop_front();
                            check("frame_bits", 32'(o), 32'(e.bits));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int         n;
        bus_if.tx_data  = '0;
        bus_if.tx_start = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_clk_oe",  32'(bus_if.ps2_clk_oe),  32'd0);
        check("rst_data_oe", 32'(bus_if.ps2_data_oe), 32'd0);
        check("rst_busy",    32'(bus_if.busy),        32'd0);
        check("rst_done",    32'(bus_if.done),        32'd0);
        check("rst_err",     32'(bus_if.err),         32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 0xF4 with a stray 0x00 request while busy
        expect_result(1'b0, 1'b1, ref_frame(8'hF4));
        fork
            begin
                send(8'hF4);
                check("busy_after_accept", 32'(bus_if.busy), 32'd1);
                repeat (300) @(negedge clk);
                bus_if.tx_data  = 8'h00;
                bus_if.tx_start = 1'b1;
                @(negedge clk);
                bus_if.tx_start = 1'b0;
                wait_not_busy();
            end
            device(1'b1, 11, 20);
        join
        repeat (5) @(negedge clk);

        run_frame(8'h00, 1'b1, 20);

        // 0xFF with inhibit / start-bit ordering measured
        expect_result(1'b0, 1'b1, ref_frame(8'hFF));
        fork
            begin
                send(8'hFF);
                n = 0;
                while (bus_if.ps2_clk_oe && !bus_if.ps2_data_oe && n < INH + 50) begin
                    n++;
                    @(negedge clk);
                end
                check("inhibit_cycles", 32'(n), 32'(INH));
                check("start_clk_oe",  32'(bus_if.ps2_clk_oe),  32'd1);
                check("start_data_oe", 32'(bus_if.ps2_data_oe), 32'd1);
                @(negedge clk);
                check("req_clk_released", 32'(bus_if.ps2_clk_oe),  32'd0);
                check("req_data_held",    32'(bus_if.ps2_data_oe), 32'd1);
                wait_not_busy();
            end
            device(1'b1, 11, 16);
        join
        repeat (5) @(negedge clk);

        // Device never clocks
        expect_result(1'b1, 1'b0, '0);
        send(8'($urandom));
        n = 0;
        while (!(bus_if.ps2_clk_oe == 1'b0 && bus_if.ps2_data_oe == 1'b1) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("req_reached", 32'(n < 1000), 32'd1);
        n = 0;
        while (!bus_if.err && n < TO + 100) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", 32'(n), 32'(TO));
        repeat (5) @(negedge clk);

        // Missing ACK
        run_frame(8'hA7, 1'b0, 18);

        // Reset after fall 5, with d4=0 so data is being pulled at that moment
        d = 8'($urandom) & 8'hEF;
        fork
            send(d);
            device(1'b1, 5, 20);
        join
        @(negedge clk);
        check("pre_rst_data_oe", 32'(bus_if.ps2_data_oe), 32'd1);
        check("pre_rst_busy",    32'(bus_if.busy),        32'd1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_clk_oe",  32'(bus_if.ps2_clk_oe),  32'd0);
        check("async_rst_data_oe", 32'(bus_if.ps2_data_oe), 32'd0);
        check("async_rst_busy",    32'(bus_if.busy),        32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        run_frame(8'($urandom), 1'b1, 20);

        // Randomised frames
        for (int i = 0; i < 6; i++) begin
            run_frame(8'($urandom), ($urandom_range(0, 3) != 0), int'($urandom_range(12, 30)));
        end

        repeat (20) @(negedge clk);
        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        check("obs_queue_drained", 32'(obs_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
